// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the L1-to-memory line-port arbiter.
//   arb_state_t : arbiter FSM state (idle, serving I-cache, serving D-cache)
//   arb_src_t   : requester identity, also used as the round-robin pointer
//   arb_op_t    : latched memory operation of the granted transaction
//   arb_pick()  : round-robin choice between the two requesters
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_SRC_I = 1'b0,
    ARB_SRC_D = 1'b1
  } arb_src_t;

  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op_t;

  // A tie goes to the side that was not granted last time.
  // A single requester simply wins.
  function automatic arb_src_t arb_pick(logic i_req, logic d_req, arb_src_t last);
    if (i_req && d_req) return (last == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
    else if (d_req)     return ARB_SRC_D;
    else                return ARB_SRC_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one line-port bundle (request, address, data, response).
//   master : the side that issues requests (a cache, or the arbiter toward memory)
//   slave  : the side that services requests (the arbiter toward a cache, or memory)
//   read/write/address/wdata flow master -> slave; rdata/resp flow slave -> master.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, write, address, wdata, input  rdata, resp);
  modport slave  (input  read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single memory line port to either the I-cache or the
// D-cache, one transaction at a time, round-robin on ties.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset
//   i_pmem : I-cache miss port (read only; write/wdata are ignored)
//   d_pmem : D-cache miss / writeback port
//   mem    : memory-side port; read/write/address/wdata come straight from flops
// Address, write data and operation are captured on the grant edge and held
// for the whole transaction. A completion always returns through ARB_IDLE for
// one cycle so the requester can drop its request before it could be re-granted.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  i_pmem,
  mem_arbiter_if.slave  d_pmem,
  mem_arbiter_if.master mem
);

  arb_state_t        state_q, state_d;
  arb_src_t          last_grant_q;
  arb_src_t          grant_src;
  arb_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_req, d_req, grant;
  logic              i_resp, d_resp;

  assign i_req = i_pmem.read;
  assign d_req = d_pmem.read | d_pmem.write;
  assign grant = (state_q == ARB_IDLE) && (i_req || d_req);

  // The I-cache never writes; these port members are intentionally unused.
  logic unused_i_wr;
  assign unused_i_wr = ^{i_pmem.write, i_pmem.wdata};

  // next-state and response steering
  always_comb begin
    state_d   = state_q;
    grant_src = arb_pick(i_req, d_req, last_grant_q);
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // mem.resp here is stray and deliberately dropped
        if (grant) state_d = (grant_src == ARB_SRC_D) ? ARB_D : ARB_I;
      end
      ARB_I: begin
        if (mem.resp) begin
          i_resp  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_D: begin
        if (mem.resp) begin
          d_resp  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state and transaction latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_SRC_I;  // first tie goes to D
      op_q         <= ARB_OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q <= grant_src;
        wdata_q      <= d_pmem.wdata;
        if (grant_src == ARB_SRC_I) begin
          addr_q <= i_pmem.address;
          op_q   <= ARB_OP_READ;
        end else begin
          addr_q <= d_pmem.address;
          // read+write together is illegal; write wins
          op_q   <= d_pmem.write ? ARB_OP_WRITE : ARB_OP_READ;
        end
      end
    end
  end

  // Memory side: a function of flops only, so no request input reaches mem_*.
  assign mem.read    = (state_q != ARB_IDLE) && (op_q == ARB_OP_READ);
  assign mem.write   = (state_q != ARB_IDLE) && (op_q == ARB_OP_WRITE);
  assign mem.address = addr_q;
  assign mem.wdata   = wdata_q;

  // Cache side: data is broadcast, resp qualifies it for the granted side only.
  assign i_pmem.rdata = mem.rdata;
  assign d_pmem.rdata = mem.rdata;
  assign i_pmem.resp  = i_resp;
  assign d_pmem.resp  = d_resp;

  a_d_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst)
    !(d_pmem.read && d_pmem.write));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter.
module tb_mem_arbiter;

  localparam logic [255:0] LINE_AA = {32{8'hAA}};
  localparam logic [255:0] LINE_55 = {32{8'h55}};

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if i_pmem ();
  mem_arbiter_if d_pmem ();
  mem_arbiter_if mem ();

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .i_pmem (i_pmem),
    .d_pmem (d_pmem),
    .mem    (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after the grant edge. Checks the memory request, waits
  // lat cycles, returns data, checks the steered response, then the
  // turnaround cycle.
  task automatic serve(input string tag, input logic is_d, input logic [31:0] exp_addr,
                       input logic exp_wr, input int lat, input logic [255:0] data);
    chk({tag, "_addr"}, mem.address, exp_addr);
    chk({tag, "_rd"}, mem.read, !exp_wr);
    chk({tag, "_wr"}, mem.write, exp_wr);
    repeat (lat) cyc();
    chk({tag, "_addr_hold"}, mem.address, exp_addr);
    mem.rdata = data;
    mem.resp  = 1'b1;
    #1;
    chk({tag, "_i_resp"}, i_pmem.resp, !is_d);
    chk({tag, "_d_resp"}, d_pmem.resp, is_d);
    chk({tag, "_rdata"}, is_d ? d_pmem.rdata : i_pmem.rdata, data);
    cyc();
    mem.resp  = 1'b0;
    mem.rdata = '0;
    #1;
    chk({tag, "_ta_rd"}, mem.read, 1'b0);
    chk({tag, "_ta_wr"}, mem.write, 1'b0);
    chk({tag, "_ta_resp"}, {i_pmem.resp, d_pmem.resp}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    i_pmem.read = 1'b0; i_pmem.write = 1'b0; i_pmem.address = '0; i_pmem.wdata = '0;
    d_pmem.read = 1'b0; d_pmem.write = 1'b0; d_pmem.address = '0; d_pmem.wdata = '0;
    mem.rdata = '0; mem.resp = 1'b0;

    // reset values
    repeat (2) cyc();
    chk("rst_rd", mem.read, 1'b0);
    chk("rst_wr", mem.write, 1'b0);
    chk("rst_addr", mem.address, '0);
    chk("rst_wdata", mem.wdata, '0);
    chk("rst_resp", {i_pmem.resp, d_pmem.resp}, 2'b00);
    rst = 1'b1;
    cyc();

    // I-only fill, memory answers after 3 cycles
    i_pmem.read = 1'b1; i_pmem.address = 32'h0000_1000;
    cyc();
    serve("i_only", 1'b0, 32'h1000, 1'b0, 3, LINE_AA);
    i_pmem.read = 1'b0;
    cyc();

    // D writeback; requester inputs change after the grant
    d_pmem.write = 1'b1; d_pmem.address = 32'h2000; d_pmem.wdata = LINE_55;
    cyc();
    d_pmem.address = 32'h3000; d_pmem.wdata = '0;
    #1;
    chk("d_wb_wdata", mem.wdata, LINE_55);
    serve("d_wb", 1'b1, 32'h2000, 1'b1, 2, 256'h1);
    chk("d_wb_wdata_hold", mem.wdata, LINE_55);
    d_pmem.write = 1'b0;
    cyc();

    // reset in the middle of a D write, then a stray mem_resp
    d_pmem.write = 1'b1; d_pmem.address = 32'h2000; d_pmem.wdata = LINE_55;
    cyc();
    chk("mid_wr_before", mem.write, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_wr_async", mem.write, 1'b0);
    chk("mid_addr_async", mem.address, '0);
    chk("mid_wdata_async", mem.wdata, '0);
    d_pmem.write = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    mem.resp = 1'b1; mem.rdata = LINE_AA;
    #1;
    chk("stray_resp", {i_pmem.resp, d_pmem.resp}, 2'b00);
    cyc();
    chk("stray_idle", {mem.read, mem.write}, 2'b00);
    chk("stray_resp2", {i_pmem.resp, d_pmem.resp}, 2'b00);
    mem.resp = 1'b0; mem.rdata = '0;
    cyc();

    // simultaneous pair right after reset: D first, IDLE, then I
    i_pmem.read = 1'b1; i_pmem.address = 32'h100;
    d_pmem.read = 1'b1; d_pmem.address = 32'h200;
    cyc();
    serve("pair1_d", 1'b1, 32'h200, 1'b0, 1, {8{32'hDEAD_BEEF}});
    d_pmem.read = 1'b0;
    cyc();
    serve("pair1_i", 1'b0, 32'h100, 1'b0, 0, {8{32'h1234_5678}});
    i_pmem.read = 1'b0;
    cyc();

    // D-only read makes last_grant = D, so the next tie goes to I
    d_pmem.read = 1'b1; d_pmem.address = 32'h400;
    cyc();
    serve("d_rd", 1'b1, 32'h400, 1'b0, 0, LINE_55);
    d_pmem.read = 1'b0;
    cyc();
    i_pmem.read = 1'b1; i_pmem.address = 32'h100;
    d_pmem.read = 1'b1; d_pmem.address = 32'h200;
    cyc();
    serve("pair2_i", 1'b0, 32'h100, 1'b0, 1, LINE_AA);
    i_pmem.read = 1'b0;
    cyc();
    serve("pair2_d", 1'b1, 32'h200, 1'b0, 0, {8{32'hCAFE_F00D}});
    d_pmem.read = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
